mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer sharing the single main-memory port between the instruction-cache and data-cache controllers. It accepts level-held memory requests, grants one requester at a time with round-robin fairness, and issues a one-cycle memory strobe. It times the fixed memory latency with an internal wait-state counter and returns a one-cycle ready pulse to the granted requester. It sits between the cache controllers' MStrobe/MRW outputs and the memory model.

## Interface
- WAIT_CYCLES, 4: memory latency in cycles spent in WAIT; legal range 1..255; 0 is an elaboration error.
- CTR_W, 8: wait-state counter width; must hold WAIT_CYCLES.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 (instruction cache) memory request; held until rdy0
- rw0  in  1  requester 0 direction: 1 = write, 0 = read
- req1  in  1  requester 1 (data cache) memory request; held until rdy1
- rw1  in  1  requester 1 direction
- rdy0  out  1  one-cycle completion pulse to requester 0
- rdy1  out  1  one-cycle completion pulse to requester 1
- gnt  out  2  one-hot grant (bit i = requester i); 00 when idle
- mem_strobe  out  1  one-cycle memory access start
- mem_rw  out  1  latched direction of the granted access
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE (encoding from package).
- IDLE: req0/req1 sampled only here. None -> stay. One -> grant it. Both -> grant the requester not in last_grant. At the transition: gnt and mem_rw are latched from the winner's rw, and the state moves to ISSUE.
- ISSUE: mem_strobe=1 for this cycle only; counter loaded with WAIT_CYCLES; -> WAIT.
- WAIT: counter decrements each cycle; after exactly WAIT_CYCLES cycles in WAIT -> DONE.
- DONE: rdy of the granted requester = 1 for this cycle; gnt still asserted; last_grant <= granted index; -> IDLE, where gnt clears.
- Requester contract: it drops req on the edge where it samples rdy=1, so req is already low in the following IDLE cycle. A req still high in that cycle is treated as a new request.
- rw changes and req deassertion during ISSUE/WAIT/DONE are ignored; the access completes.
- Non-granted req held high is never lost; it is served on the next IDLE.
- mem_rw stable from ISSUE through DONE; value held in IDLE (don't-care to memory).

## Timing
- All outputs registered or decoded from registered state; no combinational input-to-output path.
- Reset values: state IDLE, gnt 00, rdy0/rdy1 0, mem_strobe 0, mem_rw 0, busy 0, counter 0, last_grant 1 (requester 0 wins the first tie).
- Latency: req sampled in IDLE at cycle 0 -> mem_strobe cycle 1 -> WAIT cycles 2..WAIT_CYCLES+1 -> rdy at cycle WAIT_CYCLES+2 (6 at default).
- Back-to-back: next IDLE evaluation at cycle WAIT_CYCLES+3; strobe spacing is WAIT_CYCLES+3 cycles under continuous contention.
- Reset in any state: next cycle IDLE with all reset values; no rdy issued for the aborted access; last_grant returns to 1.
- Exactly one of rdy0/rdy1 is high, only in DONE; gnt never has both bits set.

## Structure
- Package mem_arb_pkg: state enum type (IDLE, ISSUE, WAIT, DONE), index constants REQ_INSTR=0 and REQ_DATA=1, default WAIT_CYCLES constant.
- One sub-module, mem_wait_ctr: inputs load, load value [CTR_W], enable; output done (count reached 1 while enabled). The FSM and arbitration logic stay in mem_arbiter.

## Test plan
- Reset then idle: no req for 10 cycles -> gnt=00, mem_strobe=0, busy=0, rdy0=rdy1=0 throughout.
- Single read: req0=1, rw0=0 at cycle 0 -> gnt=01 from cycle 1, mem_strobe=1 only cycle 1, mem_rw=0, rdy0=1 only cycle 6, gnt=00 cycle 7.
- Tie after reset: req0=req1=1 (rw1=1) held -> requester 0 served first (rdy0 cycle 6). Requester 1 is granted at the IDLE evaluation in cycle 7, with mem_strobe at cycle 8, mem_rw=1 and rdy1 at cycle 13. Alternation continues if both are held.
- Direction latch: grant req1 with rw1=1, toggle rw1 during WAIT -> mem_rw stays 1 through DONE.
- Reset mid-WAIT: assert reset at cycle 3 of an access -> cycle 4 all outputs at reset values, no rdy pulse ever for that access, next tie goes to requester 0.
- WAIT_CYCLES=1 build: single req1 write -> mem_strobe cycle 1, rdy1 cycle 3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
// The state encoding here is the one the arbiter FSM uses.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   localparam logic REQ_INSTR = 1'b0;
   localparam logic REQ_DATA  = 1'b1;

   localparam int DEF_WAIT_CYCLES = 4;

   // On a tie the requester that was not served last time wins.
   function automatic logic pickWinner(input logic reqInstr,
                                       input logic reqData,
                                       input logic lastGrant);
      logic winner;
      if (reqInstr && reqData) begin
         winner = (lastGrant == REQ_DATA) ? REQ_INSTR : REQ_DATA;
      end else if (reqData) begin
         winner = REQ_DATA;
      end else begin
         winner = REQ_INSTR;
      end
      return winner;
   endfunction

   function automatic logic [1:0] idxToGnt(input logic idx);
      return (idx == REQ_DATA) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Down-counter that times the fixed memory latency for the arbiter.
// done_o flags the last wait cycle so the FSM can leave WAIT on the next edge.
module mem_wait_ctr #(
   parameter int CTR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CTR_W-1:0] loadVal_i,
   input  logic             enable_i,
   output logic             done_o
);

   logic [CTR_W-1:0] cnt_q;
   logic [CTR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = loadVal_i;
      end else if (enable_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = enable_i && (cnt_q == CTR_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing the main-memory port between the
// instruction and data cache controllers; one access in flight at a time.
module mem_arbiter #(
   parameter int WAIT_CYCLES = mem_arb_pkg::DEF_WAIT_CYCLES,
   parameter int CTR_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       rw0,
   input  logic       req1,
   input  logic       rw1,
   output logic       rdy0,
   output logic       rdy1,
   output logic [1:0] gnt,
   output logic       mem_strobe,
   output logic       mem_rw,
   output logic       busy
);
   import mem_arb_pkg::*;

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : gBadWaitCycles
      $error("mem_arbiter: WAIT_CYCLES must be in 1..255");
   end
   if (WAIT_CYCLES >= (1 << CTR_W)) begin : gCtrTooNarrow
      $error("mem_arbiter: CTR_W too narrow to hold WAIT_CYCLES");
   end

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ISSUE = ISSUE;
   localparam logic [1:0] S_WAIT  = WAIT;
   localparam logic [1:0] S_DONE  = DONE;

   logic [1:0] state_q, state_d;
   logic [1:0] gnt_q, gnt_d;
   logic       memRw_q, memRw_d;
   logic       lastGrant_q, lastGrant_d;

   logic       winnerIdx;
   logic       ctrLoad;
   logic       ctrEnable;
   logic       ctrDone;

   assign winnerIdx = pickWinner(req0, req1, lastGrant_q);
   assign ctrLoad   = (state_q == S_ISSUE);
   assign ctrEnable = (state_q == S_WAIT);

   mem_wait_ctr #(
      .CTR_W (CTR_W)
   ) uWaitCtr (
      .clk       (clk),
      .reset     (reset),
      .load_i    (ctrLoad),
      .loadVal_i (CTR_W'(WAIT_CYCLES)),
      .enable_i  (ctrEnable),
      .done_o    (ctrDone)
   );

   // Requests are only looked at in IDLE; once granted, the access runs to
   // completion regardless of what the requester does with req/rw.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      memRw_d     = memRw_q;
      lastGrant_d = lastGrant_q;
      case (state_q)
         S_IDLE: begin
            gnt_d = 2'b00;
            if (req0 || req1) begin
               gnt_d   = idxToGnt(winnerIdx);
               memRw_d = (winnerIdx == REQ_DATA) ? rw1 : rw0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (ctrDone) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            lastGrant_d = gnt_q[REQ_DATA];
            gnt_d       = 2'b00;
            state_d     = S_IDLE;
         end
         default: begin
            gnt_d   = 2'b00;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         gnt_q       <= 2'b00;
         memRw_q     <= 1'b0;
         lastGrant_q <= REQ_DATA;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         memRw_q     <= memRw_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   assign gnt        = gnt_q;
   assign mem_rw     = memRw_q;
   assign mem_strobe = (state_q == S_ISSUE);
   assign busy       = (state_q != S_IDLE);
   assign rdy0       = (state_q == S_DONE) && gnt_q[REQ_INSTR];
   assign rdy1       = (state_q == S_DONE) && gnt_q[REQ_DATA];

endmodule
